// File: rtl/vga_capture_if.sv
// Pin-level bundle between a VGA source and the capture block: sync/colour
// pins in, frame-buffer write port and lock status out.
interface vga_capture_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              iHsync;
  logic              iVsync;
  logic [3:0]        iR;
  logic [3:0]        iG;
  logic [3:0]        iB;
  logic              oWrEn;
  logic [ADDR_W-1:0] oAddr;
  logic [11:0]       oPixel;
  logic              oFrameStart;
  logic              oLocked;
  logic [7:0]        oErrCnt;

  // The VGA source (or a bench) drives the pins and observes the write port.
  modport master (
    output iHsync, iVsync, iR, iG, iB,
    input  oWrEn, oAddr, oPixel, oFrameStart, oLocked, oErrCnt
  );

  modport slave (
    input  iHsync, iVsync, iR, iG, iB,
    output oWrEn, oAddr, oPixel, oFrameStart, oLocked, oErrCnt
  );
endinterface

// File: rtl/vga_capture.sv
// VGA receive stage: rebuilds H/V position from sync edges, qualifies the
// timing with a lock FSM and, once locked, writes each active pixel to memory.
module vga_capture #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT       = 640,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACT       = 480,
  parameter int unsigned ADDR_W      = 19
) (
  input  logic          iClk,
  input  logic          iRst_n,
  vga_capture_if.slave  bus
);

  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_TMO   = 12'(2 * H_TOTAL);
  localparam logic [11:0] H_A0    = 12'(H_ACT_START);
  localparam logic [11:0] H_A1    = 12'(H_ACT_START + H_ACT - 1);
  localparam logic [11:0] V_A0    = 12'(V_ACT_START);
  localparam logic [11:0] V_A1    = 12'(V_ACT_START + V_ACT - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACT * V_ACT - 1);

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } state_e;

  // Input register stage
  logic        hsync_q, vsync_q;
  logic        hsync_prev_q, vsync_prev_q;
  logic [11:0] rgb_q;

  // NOTE: every sequential element uses <= so all flops sample pre-edge values
  // together; a blocking = here would let hsync_prev_q see this cycle's hsync_q.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      hsync_prev_q <= 1'b0;
      vsync_prev_q <= 1'b0;
      rgb_q        <= '0;
    end else begin
      hsync_q      <= bus.iHsync;
      vsync_q      <= bus.iVsync;
      hsync_prev_q <= hsync_q;
      vsync_prev_q <= vsync_q;
      rgb_q        <= {bus.iB, bus.iG, bus.iR};
    end
  end

  logic h_rise, v_rise;
  assign h_rise = hsync_q & ~hsync_prev_q;
  assign v_rise = vsync_q & ~vsync_prev_q;

  // Position counters and timing checks
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        line_bad, frame_bad, v_orphan, timeout;
  logic        err_event;
  state_e      state_q, state_d;

  // h_cnt_d/v_cnt_d are the coordinates of the sample now sitting in rgb_q:
  // the h_rise sample is HCount 0, so the registered count lags by one.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (h_rise) begin
      h_cnt_d = '0;
      if (v_rise) begin
        v_cnt_d = '0;
      end else if (v_cnt_q != CNT_MAX) begin
        v_cnt_d = v_cnt_q + 12'd1;
      end
    end else if (h_cnt_q != CNT_MAX) begin
      h_cnt_d = h_cnt_q + 12'd1;
    end
  end

  assign line_bad  = h_rise & (h_cnt_q != H_LAST);
  assign frame_bad = v_rise & (v_cnt_q != V_LAST);
  assign v_orphan  = v_rise & ~h_rise;
  // Fires exactly once per missing-sync stretch, as h_cnt passes 2*H_TOTAL.
  assign timeout   = ~h_rise & (h_cnt_d == H_TMO) & (h_cnt_q != H_TMO);
  assign err_event = (state_q != SEARCH) &
                     (line_bad | frame_bad | v_orphan | timeout);

  // Lock FSM next state; an error beats a simultaneous v_rise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH: begin
        if (v_rise) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (err_event)   state_d = SEARCH;
        else if (v_rise) state_d = LOCKED;
      end
      LOCKED: begin
        if (err_event) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  // Write path decisions
  logic              lock_d;
  logic              active;
  logic              wr_d;
  logic              frame_start_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  assign lock_d        = (state_d == LOCKED);
  assign active        = (h_cnt_d >= H_A0) && (h_cnt_d <= H_A1) &&
                         (v_cnt_d >= V_A0) && (v_cnt_d <= V_A1);
  assign wr_d          = lock_d & active;
  assign frame_start_d = lock_d & v_rise;

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    addr_d = addr_q;
    if (frame_start_d) begin
      addr_d = '0;
    end else if (wr_d && (addr_q != ADDR_MAX)) begin
      addr_d = addr_q + 1'b1;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == LOCKED) && err_event && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= SEARCH;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      addr_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Registered output port; address and pixel hold between writes.
  logic              wr_en_q;
  logic [ADDR_W-1:0] addr_out_q;
  logic [11:0]       pixel_q;
  logic              frame_start_q;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wr_en_q       <= 1'b0;
      addr_out_q    <= '0;
      pixel_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      wr_en_q       <= wr_d;
      frame_start_q <= frame_start_d;
      if (wr_d) begin
        addr_out_q <= addr_q;
        pixel_q    <= rgb_q;
      end
    end
  end

  assign bus.oWrEn       = wr_en_q;
  assign bus.oAddr       = addr_out_q;
  assign bus.oPixel      = pixel_q;
  assign bus.oFrameStart = frame_start_q;
  assign bus.oLocked     = (state_q == LOCKED);
  assign bus.oErrCnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a scaled-down raster; expected writes are
// queued as pixels are driven and popped as the DUT emits them.
module tb_vga_capture;

  localparam int H_TOTAL     = 40;
  localparam int V_TOTAL     = 20;
  localparam int H_ACT_START = 8;
  localparam int H_ACT       = 24;
  localparam int V_ACT_START = 3;
  localparam int V_ACT       = 14;
  localparam int ADDR_W      = 9;
  localparam int H_SYNC      = 4;
  localparam int V_SYNC      = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_capture_if #(.ADDR_W(ADDR_W)) bus ();

  vga_capture #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .H_ACT_START(H_ACT_START), .H_ACT(H_ACT),
    .V_ACT_START(V_ACT_START), .V_ACT(V_ACT),
    .ADDR_W(ADDR_W)
  ) dut (
    .iClk(clk),
    .iRst_n(rst_n),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [11:0]       px;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total = 0;
  int  bad = 0;
  int  fs_seen = 0;
  int  cyc = 0;
  int  t_first_drv = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.oFrameStart === 1'b1) fs_seen++;
    if (bus.oWrEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected_addr", 32'(bus.oAddr), 32'hDEAD);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.oAddr), 32'(mon_e.addr));
        check("wr_pixel", 32'(bus.oPixel), 32'(mon_e.px));
        if (mon_e.addr == '0) check("first_wr_latency", 32'(cyc - t_first_drv), 32'd2);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check(tag, {bus.oWrEn, 9'(bus.oAddr), bus.oPixel, bus.oFrameStart,
                bus.oLocked, bus.oErrCnt}, 32'd0);
  endtask

  // fault: 0 none, 1 line 5 one clock short, 2 hsync missing on lines 6-7,
  // 3 reset pulse at the start of line 10. cap_end: lines below it are captured.
  task automatic drive_frame(input int fault, input int cap_end, input bit cst,
                             input bit lock_mid, input bit lock_end,
                             input int fs_exp, input int err_exp);
    int   addr;
    int   len;
    logic [7:0] hx;
    logic [3:0] r, g, b;
    wr_t  e;
    addr = 0;
    fs_seen = 0;
    for (int v = 0; v < V_TOTAL; v++) begin
      len = (fault == 1 && v == 5) ? H_TOTAL - 1 : H_TOTAL;
      for (int h = 0; h < len; h++) begin
        if (fault == 3 && v == 10 && h == 0) begin
          rst_n = 1'b0;
          #1;
          check_outputs_zero("reset_mid_frame");
        end
        if (fault == 3 && v == 10 && h == 6) rst_n = 1'b1;
        hx = 8'(h);
        if (cst) begin
          r = 4'hA; g = 4'h5; b = 4'h3;
        end else begin
          b = hx[3:0]; g = 4'(v); r = hx[7:4];
        end
        bus.iHsync = (h < H_SYNC) && !(fault == 2 && (v == 6 || v == 7));
        bus.iVsync = (v < V_SYNC);
        bus.iR = r; bus.iG = g; bus.iB = b;
        if (v < cap_end && h >= H_ACT_START && h < H_ACT_START + H_ACT &&
            v >= V_ACT_START && v < V_ACT_START + V_ACT) begin
          e.addr = ADDR_W'(addr);
          e.px   = cst ? 12'h35A : {b, g, r};
          exp_q.push_back(e);
          if (addr == 0) t_first_drv = cyc;
          addr++;
        end
        @(posedge clk);
        #1;
      end
      if (v == 2) check("locked_mid", 32'(bus.oLocked), 32'(lock_mid));
    end
    check("frame_start_cnt", 32'(fs_seen), 32'(fs_exp));
    check("locked_end", 32'(bus.oLocked), 32'(lock_end));
    check("err_cnt", 32'(bus.oErrCnt), 32'(err_exp));
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.iHsync = 1'b0; bus.iVsync = 1'b0;
    bus.iR = '0; bus.iG = '0; bus.iB = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Acquire, lock, capture two full frames.
    drive_frame(0, 0,       0, 0, 0, 0, 0);
    drive_frame(0, V_TOTAL, 0, 1, 1, 1, 0);
    drive_frame(0, V_TOTAL, 0, 1, 1, 1, 0);
    // Short line while locked, then relock.
    drive_frame(1, 6,       0, 1, 0, 1, 1);
    drive_frame(0, 0,       0, 0, 0, 0, 1);
    drive_frame(0, V_TOTAL, 0, 1, 1, 1, 1);
    // Missing hsync times out, then relock.
    drive_frame(2, 6,       0, 1, 0, 1, 2);
    drive_frame(0, 0,       0, 0, 0, 0, 2);
    drive_frame(0, V_TOTAL, 0, 1, 1, 1, 2);
    // Reset mid-frame clears the error count; two v_rise events relock.
    drive_frame(3, 10,      0, 1, 0, 1, 0);
    drive_frame(0, 0,       0, 0, 0, 0, 0);
    drive_frame(0, V_TOTAL, 0, 1, 1, 1, 0);
    // Constant colour everywhere: packing and blanking.
    drive_frame(0, V_TOTAL, 1, 1, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of the VGA output stage: samples the active-high hsync/vsync and 4-bit R/G/B pins and regenerates local H/V counters from sync edges.
- Qualifies timing with a lock state machine; once locked, emits one memory write per active pixel with a linear frame-buffer address.
- Used for loopback verification of the VGA path and for capturing a frame back into memory.

Parameters:
- H_TOTAL, 800, clocks per line
- V_TOTAL, 525, lines per frame
- H_ACT_START, 144, first active h_cnt
- H_ACT, 640, active pixels per line
- V_ACT_START, 35, first active v_cnt
- V_ACT, 480, active lines
- ADDR_W, 19, write address width

Ports:
- iClk  in  1  pixel clock, same clock as the transmitter
- iRst_n  in  1  asynchronous active-low reset
- iHsync  in  1  horizontal sync, active high
- iVsync  in  1  vertical sync, active high
- iR  in  4  red
- iG  in  4  green
- iB  in  4  blue
- oWrEn  out  1  pixel write strobe
- oAddr  out  ADDR_W  write address
- oPixel  out  12  packed pixel {B,G,R} (R=[3:0], G=[7:4], B=[11:8])
- oFrameStart  out  1  one-cycle pulse at each frame start while locked
- oLocked  out  1  high in LOCKED
- oErrCnt  out  8  saturating count of lock losses

Behaviour:
Reset (iRst_n low, async):
- All registers clear: outputs 0, state SEARCH, h_cnt=0, v_cnt=0, write address 0.
- Asserting reset mid-frame aborts capture immediately.

Input stage:
- All pins registered once.
- h_rise = hsync_q & ~hsync_prev; v_rise = vsync_q & ~vsync_prev, both taken on the registered signals.

Counters (12 bits):
- On h_rise: h_cnt<=0. Otherwise h_cnt increments, saturating at 4095.
- On h_rise with v_rise: v_cnt<=0. On h_rise alone: v_cnt increments, saturating.
- A v_rise without a coincident h_rise is a timing error.
- The sample taken on h_rise corresponds to transmitter HCount 0.

Checks:
- line_ok: on h_rise, h_cnt must equal H_TOTAL-1.
- frame_ok: on v_rise, v_cnt must equal V_TOTAL-1.
- timeout: h_cnt reaching 2*H_TOTAL with no h_rise.
- Any failed check or timeout is an error event.

FSM:
- SEARCH: go to ACQUIRE on first v_rise; no checks are applied.
- ACQUIRE:
  - An error event returns to SEARCH.
  - The next v_rise with frame_ok, after all lines in between were line_ok, goes to LOCKED.
- LOCKED:
  - Any error event goes to SEARCH and increments oErrCnt, saturating at 255.
  - oErrCnt is cleared only by reset.
- An error event on the same cycle as a v_rise wins: go to SEARCH.

Write path (LOCKED only):
- active = h_cnt in [H_ACT_START, H_ACT_START+H_ACT-1] and v_cnt in [V_ACT_START, V_ACT_START+V_ACT-1].
- On v_rise in LOCKED, including the entry cycle: write address <= 0, oFrameStart pulses 1 cycle.
- For each active sample:
  - oWrEn=1, oPixel={B,G,R}, oAddr=current address.
  - Address then increments.
- The address never exceeds H_ACT*V_ACT-1 (307199); it saturates if extra active samples appear before the next v_rise.
- Outputs are registered. Latency is 2 clocks from pin to oWrEn/oPixel: input register, then output register.
- Lock loss mid-frame stops oWrEn on the cycle after the error event. No further writes occur until the next LOCKED entry, which restarts at address 0.
- Pixels outside the active window are ignored, even if they are nonzero.

Test Plan:
- Nominal: drive 3 frames of 800x525 timing (hsync high h 0..96, vsync high lines 0..2) with pixel = {x[3:0],y[3:0],x[7:4]} -> oLocked rises at start of frame 2; exactly 307200 oWrEn pulses in frame 2; first write oAddr=0 at 2 clocks after h=144,v=35; last write oAddr=307199; oFrameStart pulses once per frame.
- Wrap: run to frame 3 -> first write of frame 3 has oAddr=0, 307200 writes again, oErrCnt=0.
- Bad line: while locked, make one line 799 clocks -> oLocked falls on that hsync rise, oWrEn stops, oErrCnt=1; correct timing resumes -> relock after one good frame.
- Missing hsync: hold iHsync low for 1600 clocks while locked -> SEARCH on timeout, oErrCnt increments; writes resume only from address 0 after relock.
- Reset mid-frame: drop iRst_n at v=200 while locked -> all outputs 0 immediately, oErrCnt=0; after release, lock reacquires after two v_rise events.
- Packing/blanking: drive R=4'hA, G=4'h5, B=4'h3 everywhere -> every oPixel=12'h35A; no oWrEn at h<144, h>783, v<35 or v>514.
